// File: rtl/riscv_pipe_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pipe_pkg
//   Shared types and default constants for the 5-stage core's pipeline
//   control blocks.
//
//   Contents:
//     stall_state_t        - front-end stall controller state {RUN, LU_STALL}
//     LU_STALL_CYCLES_DEF  - default front-end stall length per load-use hazard
//     CNT_W_DEF            - default performance counter width
//     LU_CNT_W             - width of the stall down-counter (covers 1..15)
// -----------------------------------------------------------------------------
package riscv_pipe_pkg;

    // RUN      : pipeline flowing, or a single-cycle stall being applied
    // LU_STALL : extra front-end stall cycles of a multi-cycle load-use stall
    typedef enum logic [0:0] {
        RUN      = 1'b0,
        LU_STALL = 1'b1
    } stall_state_t;

    localparam int LU_STALL_CYCLES_DEF = 1;
    localparam int CNT_W_DEF           = 32;
    localparam int LU_CNT_W            = 4;

endpackage

// File: rtl/perf_counter.sv
// -----------------------------------------------------------------------------
// perf_counter
//   Free-running event counter; increments by one on every rising clock edge
//   where inc is high and wraps modulo 2^CNT_W.
//
//   Parameters:
//     CNT_W  - counter width
//   Ports:
//     clk    in   1      clock
//     rst_n  in   1      asynchronous active-low reset (count -> 0)
//     inc    in   1      count this cycle
//     count  out  CNT_W  current count
// -----------------------------------------------------------------------------
module perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_stall_ctrl
//   Turns hazard requests (load-use stall, taken-branch flush, data-memory
//   busy) into write enables, flushes and holds for the pipeline registers of
//   the 5-stage core. Control outputs are combinational from the current state
//   and the inputs, so a request takes effect in the same cycle.
//
//   Priority each cycle: mem_busy > flush (flush_req | flush_pend) > stall.
//   A flush that arrives while memory is busy is remembered in flush_pend and
//   applied in the first non-busy cycle.
//
//   Configuration macro:
//     STALL_STATS_EN  - when defined, stall_cycles and flush_count are real
//                       counters; otherwise the ports are tied to zero and no
//                       counter flops exist.
//
//   Parameters:
//     LU_STALL_CYCLES  front-end stall cycles per load-use request (1..15)
//     CNT_W            performance counter width
//
//   Ports:
//     clk           in   1       clock, rising edge
//     rst_n         in   1       asynchronous active-low reset
//     stall_req     in   1       load-use hazard request
//     flush_req     in   1       branch/jump resolved taken in EX
//     mem_busy      in   1       data memory not ready, freeze whole pipe
//     pc_we         out  1       PC write enable
//     ifid_we       out  1       IF/ID write enable
//     ifid_flush    out  1       clear IF/ID to NOP
//     idex_flush    out  1       clear ID/EX control to NOP (bubble)
//     pipe_hold     out  1       hold ID/EX, EX/MEM and MEM/WB
//     stall_cycles  out  CNT_W   cycles with pc_we=0
//     flush_count   out  CNT_W   flushes applied
//     fsm_state     out  1       current controller state (debug visibility)
//
//   Handshake: there is no valid/ready pairing here. Every request input is a
//   level sampled each cycle; the controller answers in the same cycle and
//   never back-pressures the requester.
// -----------------------------------------------------------------------------
module pipeline_stall_ctrl
    import riscv_pipe_pkg::*;
#(
    parameter int LU_STALL_CYCLES = LU_STALL_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_req,
    input  logic             flush_req,
    input  logic             mem_busy,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             pipe_hold,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output stall_state_t     fsm_state
);

    // Down-counter load value: the request cycle itself is the first stall
    // cycle, so LU_STALL covers the remaining LU_STALL_CYCLES-1.
    localparam logic [LU_CNT_W-1:0] LU_INIT = LU_CNT_W'(LU_STALL_CYCLES - 1);
    localparam logic [LU_CNT_W-1:0] CNT_ONE = LU_CNT_W'(1);
    localparam bit                  MULTI   = (LU_STALL_CYCLES > 1);

    stall_state_t        state,      state_nxt;
    logic [LU_CNT_W-1:0] cnt,        cnt_nxt;
    logic                flush_pend, flush_pend_nxt;

    logic do_flush;
    logic do_stall;

    // Flush wins over any stall, including one already in progress.
    assign do_flush = !mem_busy && (flush_req || flush_pend);
    assign do_stall = !mem_busy && !do_flush &&
                      ((state == LU_STALL) || stall_req);

    assign fsm_state = state;

    // -------------------------------------------------------------------------
    // Pipeline-register control. Reset forces the free-running pattern even if
    // requests are asserted, so the pipe comes out of reset cleanly.
    // -------------------------------------------------------------------------
    always_comb begin
        pc_we      = 1'b1;
        ifid_we    = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        pipe_hold  = 1'b0;
        if (!rst_n) begin
            pc_we = 1'b1;
        end else if (mem_busy) begin
            pc_we     = 1'b0;
            ifid_we   = 1'b0;
            pipe_hold = 1'b1;
        end else if (do_flush) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (do_stall) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        flush_pend_nxt = flush_pend;
        if (mem_busy) begin
            // Whole pipe frozen: the stall count stands still and a taken
            // branch is parked until memory frees up.
            flush_pend_nxt = flush_pend || flush_req;
        end else if (do_flush) begin
            state_nxt      = RUN;
            cnt_nxt        = '0;
            flush_pend_nxt = 1'b0;
        end else if (state == LU_STALL) begin
            if (cnt == CNT_ONE) begin
                state_nxt = RUN;
                cnt_nxt   = '0;
            end else begin
                cnt_nxt = cnt - CNT_ONE;
            end
        end else if (stall_req && MULTI) begin
            state_nxt = LU_STALL;
            cnt_nxt   = LU_INIT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            cnt        <= '0;
            flush_pend <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            flush_pend <= flush_pend_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Performance counters
    // -------------------------------------------------------------------------
`ifdef STALL_STATS_EN
    perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (!pc_we),
        .count (stall_cycles)
    );

    perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (do_flush),
        .count (flush_count)
    );
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_stall_ctrl
//   Three controllers (LU_STALL_CYCLES = 1, 2, 3) share one set of request
//   inputs. Each is compared every cycle against a reference model that keeps
//   "remaining extra stall cycles" and a parked-flush bit per instance.
// -----------------------------------------------------------------------------
module tb_pipeline_stall_ctrl;
    import riscv_pipe_pkg::*;

    localparam int NI = 3;
    localparam int VW = 5 + 1 + 32 + 32;

`ifdef STALL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic stall_req = 1'b0;
    logic flush_req = 1'b0;
    logic mem_busy  = 1'b0;

    logic         pc_we_a   [NI];
    logic         ifid_we_a [NI];
    logic         ifidf_a   [NI];
    logic         idexf_a   [NI];
    logic         hold_a    [NI];
    logic [31:0]  sc_a      [NI];
    logic [31:0]  fc_a      [NI];
    stall_state_t st_a      [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        pipeline_stall_ctrl #(.LU_STALL_CYCLES(g + 1), .CNT_W(32)) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .stall_req    (stall_req),
            .flush_req    (flush_req),
            .mem_busy     (mem_busy),
            .pc_we        (pc_we_a[g]),
            .ifid_we      (ifid_we_a[g]),
            .ifid_flush   (ifidf_a[g]),
            .idex_flush   (idexf_a[g]),
            .pipe_hold    (hold_a[g]),
            .stall_cycles (sc_a[g]),
            .flush_count  (fc_a[g]),
            .fsm_state    (st_a[g])
        );
    end

    int checks   = 0;
    int failures = 0;

    // reference model state
    int          rem  [NI];
    bit          pend [NI];
    logic [31:0] m_sc [NI];
    logic [31:0] m_fc [NI];
    logic [VW-1:0] exp_v [NI];

    function automatic logic [VW-1:0] obs_v(input int i);
        return {pc_we_a[i], ifid_we_a[i], ifidf_a[i], idexf_a[i], hold_a[i],
                st_a[i], sc_a[i], fc_a[i]};
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NI; i++) begin
            rem[i] = 0; pend[i] = 1'b0; m_sc[i] = '0; m_fc[i] = '0;
        end
    endfunction

    // Expected outputs for the inputs currently applied.
    // Control order: {pc_we, ifid_we, ifid_flush, idex_flush, pipe_hold}.
    function automatic void model_eval();
        logic [4:0]  ctl;
        logic [31:0] sc, fc;
        for (int i = 0; i < NI; i++) begin
            if (!rst_n)                      ctl = 5'b11000;
            else if (mem_busy)               ctl = 5'b00001;
            else if (flush_req || pend[i])   ctl = 5'b11110;
            else if (rem[i] > 0 || stall_req) ctl = 5'b00010;
            else                             ctl = 5'b11000;
            sc = STATS ? m_sc[i] : 32'd0;
            fc = STATS ? m_fc[i] : 32'd0;
            exp_v[i] = {ctl, (rem[i] > 0) ? LU_STALL : RUN, sc, fc};
        end
    endfunction

    function automatic void model_clock();
        for (int i = 0; i < NI; i++) begin
            if (!rst_n) begin
                rem[i] = 0; pend[i] = 1'b0; m_sc[i] = '0; m_fc[i] = '0;
            end else if (mem_busy) begin
                pend[i] = pend[i] | flush_req;
                m_sc[i] = m_sc[i] + 1;
            end else if (flush_req || pend[i]) begin
                rem[i] = 0; pend[i] = 1'b0;
                m_fc[i] = m_fc[i] + 1;
            end else if (rem[i] > 0) begin
                rem[i] = rem[i] - 1;
                m_sc[i] = m_sc[i] + 1;
            end else if (stall_req) begin
                rem[i] = (i + 1) - 1;
                m_sc[i] = m_sc[i] + 1;
            end
        end
    endfunction

    // driver tasks: inputs change 1ns after posedge, outputs are looked at on
    // the falling edge, the model advances on the rising edge.
    task automatic apply(input logic s, input logic f, input logic b);
        stall_req = s; flush_req = f; mem_busy = b;
        @(negedge clk);
        model_eval();
    endtask

    task automatic advance();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic do_reset();
        stall_req = 0; flush_req = 0; mem_busy = 0;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        // Start in LU_STALL on the 3-cycle instance, then reset mid-stall with
        // stall_req still high.
        do_reset();
        apply(1'b1, 1'b0, 1'b0);
        advance();
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (i == 2 && st_a[i] !== LU_STALL) begin
                failures++;
                $display("FAIL reset_pre[%0d]: state got %0d want %0d", i, st_a[i], LU_STALL);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (obs_v(i) !== {5'b11000, RUN, 32'd0, 32'd0}) begin
                failures++;
                $display("FAIL reset_async[%0d]: got %h want %h", i, obs_v(i),
                         {5'b11000, RUN, 32'd0, 32'd0});
            end
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        stall_req = 1'b0;
    endtask

    task automatic test_load_use();
        int nstall;
        do_reset();
        nstall = 0;
        for (int c = 0; c < 3; c++) begin
            apply(c == 0, 1'b0, 1'b0);
            if (!pc_we_a[0]) nstall++;
            for (int i = 0; i < NI; i++) begin
                checks++;
                if (obs_v(i) !== exp_v[i]) begin
                    failures++;
                    $display("FAIL load_use[%0d] cyc %0d: got %h want %h", i, c, obs_v(i), exp_v[i]);
                end
            end
            advance();
        end
        checks++;
        if (nstall !== 1 || sc_a[0] !== (STATS ? 32'd1 : 32'd0)) begin
            failures++;
            $display("FAIL load_use_count: stalls %0d sc %0d want 1 sc %0d", nstall, sc_a[0], STATS ? 1 : 0);
        end
    endtask

    task automatic test_extended_stall();
        int nstall;
        do_reset();
        nstall = 0;
        for (int c = 0; c < 5; c++) begin
            apply(c == 0, 1'b0, 1'b0);
            if (!pc_we_a[2] && idexf_a[2]) nstall++;
            for (int i = 0; i < NI; i++) begin
                checks++;
                if (obs_v(i) !== exp_v[i]) begin
                    failures++;
                    $display("FAIL ext_stall[%0d] cyc %0d: got %h want %h", i, c, obs_v(i), exp_v[i]);
                end
            end
            advance();
        end
        checks++;
        if (nstall !== 3 || st_a[2] !== RUN) begin
            failures++;
            $display("FAIL ext_stall_len: got %0d cycles state %0d want 3 state 0", nstall, st_a[2]);
        end
    endtask

    task automatic test_flush_and_stall();
        int nstall;
        do_reset();
        nstall = 0;
        for (int c = 0; c < 4; c++) begin
            apply(c == 0, c == 0, 1'b0);
            if (!pc_we_a[2]) nstall++;
            for (int i = 0; i < NI; i++) begin
                checks++;
                if (obs_v(i) !== exp_v[i]) begin
                    failures++;
                    $display("FAIL flush_stall[%0d] cyc %0d: got %h want %h", i, c, obs_v(i), exp_v[i]);
                end
            end
            advance();
        end
        checks++;
        if (nstall !== 0 || fc_a[2] !== (STATS ? 32'd1 : 32'd0)) begin
            failures++;
            $display("FAIL flush_stall_sum: stalls %0d fc %0d want 0 fc %0d", nstall, fc_a[2], STATS ? 1 : 0);
        end
    endtask

    task automatic test_deferred_flush();
        int nflush;
        do_reset();
        nflush = 0;
        for (int c = 0; c < 5; c++) begin
            apply(1'b0, c < 2, c < 2);
            if (ifidf_a[0] && idexf_a[0]) nflush++;
            for (int i = 0; i < NI; i++) begin
                checks++;
                if (obs_v(i) !== exp_v[i]) begin
                    failures++;
                    $display("FAIL deferred[%0d] cyc %0d: got %h want %h", i, c, obs_v(i), exp_v[i]);
                end
            end
            advance();
        end
        checks++;
        if (nflush !== 1) begin
            failures++;
            $display("FAIL deferred_once: got %0d flushes want 1", nflush);
        end
    endtask

    task automatic test_busy_in_stall();
        int nstall;
        logic [2:0] b;
        do_reset();
        nstall = 0;
        b = 3'b000;
        for (int c = 0; c < 6; c++) begin
            b = (c == 1 || c == 2) ? 3'b001 : 3'b000;
            apply(c == 0, 1'b0, b[0]);
            if (!pc_we_a[1]) nstall++;
            for (int i = 0; i < NI; i++) begin
                checks++;
                if (obs_v(i) !== exp_v[i]) begin
                    failures++;
                    $display("FAIL busy_stall[%0d] cyc %0d: got %h want %h", i, c, obs_v(i), exp_v[i]);
                end
            end
            advance();
        end
        checks++;
        if (nstall !== 4 || sc_a[1] !== (STATS ? 32'd4 : 32'd0)) begin
            failures++;
            $display("FAIL busy_stall_sum: stalls %0d sc %0d want 4 sc %0d", nstall, sc_a[1], STATS ? 4 : 0);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            apply($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 12,
                  $urandom_range(0, 99) < 20);
            for (int i = 0; i < NI; i++) begin
                checks++;
                if (obs_v(i) !== exp_v[i]) begin
                    failures++;
                    $display("FAIL random[%0d] cyc %0d: got %h want %h", i, c, obs_v(i), exp_v[i]);
                end
            end
            advance();
        end
    endtask

    initial begin
        model_reset();
        #1;
        test_reset();
        test_load_use();
        test_extended_stall();
        test_flush_and_stall();
        test_deferred_flush();
        test_busy_in_stall();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation ran past 200000 ns");
        $fatal(1, "timeout");
    end

endmodule
